// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter for the LCD character-buffer write port, plus repaint scheduling.
// Optional grant timeout and lockout: define LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter #(
  parameter int unsigned MIN_GAP = 2097152,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       CLK12,
  input  logic       reset_n,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_we,
  input  logic       b_we,
  input  logic [4:0] a_addr,
  input  logic [4:0] b_addr,
  input  logic [7:0] a_dat,
  input  logic [7:0] b_dat,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic [7:0] lcd_dat,
  output logic [4:0] lcd_addr,
  output logic       lcd_we,
  output logic       lcd_repaint,
  input  logic       lcd_busy,
  output logic       dirty,
  output logic       timeout
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);

  typedef enum logic [2:0] {IDLE, GNT_A, GNT_B, PAINT_ACK, PAINT} state_t;

  state_t             state, state_nxt;
  logic               last_b;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         ack_cnt;
  logic               fire;
  logic               gap_ok;
  logic               wr_a, wr_b;
  logic               a_ok, b_ok;
  logic               gnt_expire;

  assign a_gnt = (state == GNT_A);
  assign b_gnt = (state == GNT_B);
  assign wr_a  = a_gnt & a_req & a_we;
  assign wr_b  = b_gnt & b_req & b_we;

  // The strobe is registered, so eligibility is judged one cycle early to keep
  // strobe-to-strobe spacing at exactly MIN_GAP.
  assign gap_ok = (gap_cnt >= GAP_W'(MIN_GAP - 1));

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] gnt_cnt;
  logic            a_lock, b_lock;
  logic            to_evt;

  assign gnt_expire = (gnt_cnt == TO_W'(TIMEOUT - 1));
  assign to_evt     = ((a_gnt & a_req) | (b_gnt & b_req)) & gnt_expire;
  assign a_ok       = a_req & ~a_lock;
  assign b_ok       = b_req & ~b_lock;

  // A timed-out requester stays locked out until it drops its request once.
  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt <= '0;
      a_lock  <= 1'b0;
      b_lock  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      gnt_cnt <= (a_gnt | b_gnt) ? gnt_cnt + 1'b1 : '0;
      timeout <= to_evt;
      if (!a_req)                a_lock <= 1'b0;
      else if (to_evt && a_gnt)  a_lock <= 1'b1;
      if (!b_req)                b_lock <= 1'b0;
      else if (to_evt && b_gnt)  b_lock <= 1'b1;
    end
  end
`else
  assign gnt_expire = 1'b0;
  assign a_ok       = a_req;
  assign b_ok       = b_req;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (dirty && gap_ok && !lcd_busy) begin
          fire      = 1'b1;
          state_nxt = PAINT_ACK;
        end else if (!lcd_busy && (a_ok || b_ok)) begin
          if (a_ok && (!b_ok || last_b)) state_nxt = GNT_A;
          else                           state_nxt = GNT_B;
        end
      end
      GNT_A: begin
        if (!a_req || gnt_expire) state_nxt = IDLE;
      end
      GNT_B: begin
        if (!b_req || gnt_expire) state_nxt = IDLE;
      end
      PAINT_ACK: begin
        // An LCD that never reports busy is treated as having finished.
        if (lcd_busy)              state_nxt = PAINT;
        else if (ack_cnt == 2'd3)  state_nxt = IDLE;
      end
      PAINT: begin
        if (!lcd_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      gap_cnt     <= GAP_W'(MIN_GAP);
      ack_cnt     <= 2'd0;
      lcd_repaint <= 1'b0;
      dirty       <= 1'b0;
    end else begin
      state       <= state_nxt;
      lcd_repaint <= fire;
      ack_cnt     <= (state == PAINT_ACK) ? ack_cnt + 2'd1 : 2'd0;
      if (a_gnt && state_nxt == IDLE) last_b <= 1'b0;
      if (b_gnt && state_nxt == IDLE) last_b <= 1'b1;
      if (fire)                         gap_cnt <= '0;
      else if (gap_cnt != GAP_W'(MIN_GAP)) gap_cnt <= gap_cnt + 1'b1;
      if (fire)              dirty <= 1'b0;
      else if (wr_a || wr_b) dirty <= 1'b1;
    end
  end

  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) begin
      lcd_we   <= 1'b0;
      lcd_addr <= 5'd0;
      lcd_dat  <= 8'd0;
    end else begin
      lcd_we <= wr_a | wr_b;
      if (wr_a) begin
        lcd_addr <= a_addr;
        lcd_dat  <= a_dat;
      end else if (wr_b) begin
        lcd_addr <= b_addr;
        lcd_dat  <= b_dat;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios plus randomized write transactions,
// with a behavioural LCD and an always-on checker for grants, dirty and repaint spacing.
module tb_lcd_write_arbiter;
  localparam int MIN_GAP = 100;
  localparam int TIMEOUT = 64;

  logic       CLK12 = 1'b0;
  logic       reset_n;
  logic       a_req, b_req, a_we, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_dat, b_dat;
  logic       a_gnt, b_gnt;
  logic [7:0] lcd_dat;
  logic [4:0] lcd_addr;
  logic       lcd_we, lcd_repaint, lcd_busy, dirty, timeout;
  logic       busy_force, busy_auto;

  always #5 CLK12 = ~CLK12;
  assign lcd_busy = busy_force | busy_auto;

  lcd_write_arbiter #(.MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK12(CLK12), .reset_n(reset_n),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_dat(a_dat), .b_dat(b_dat),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .lcd_dat(lcd_dat), .lcd_addr(lcd_addr), .lcd_we(lcd_we),
    .lcd_repaint(lcd_repaint), .lcd_busy(lcd_busy),
    .dirty(dirty), .timeout(timeout)
  );

  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  bit   m_dirty = 1'b0;
  bit   m_last = 1'b1;
  logic [4:0] m_addr = 5'd0;
  logic [7:0] m_dat = 8'd0;
  int   last_rep = -100000;
  bit   prev_rep = 1'b0;
  bit   lcd_auto = 1'b1;
  int   paint_left = 0;
  bit         w_we[8];
  logic [4:0] w_addr[8];
  logic [7:0] w_dat[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK12) cyc <= cyc + 1;

  // Invariant checker, sampled 2 time units after each rising edge.
  always @(posedge CLK12) begin
    #2;
    if (!reset_n) last_rep = -100000;
    chk("excl_gnt", {31'd0, a_gnt & b_gnt}, 0);
    if (lcd_repaint) begin
      chk("rep_when_dirty", {31'd0, m_dirty}, 1);
      chk("rep_min_gap", {31'd0, (cyc - last_rep) >= MIN_GAP}, 1);
      chk("rep_one_cycle", {31'd0, prev_rep}, 0);
      m_dirty = 1'b0;
      last_rep = cyc;
    end
    prev_rep = lcd_repaint;
    chk("dirty_track", {31'd0, dirty}, {31'd0, m_dirty});
  end

  // Behavioural LCD: goes busy as soon as it sees a strobe, for a few cycles.
  always @(negedge CLK12) begin
    if (!lcd_auto) begin
      busy_auto = 1'b0;
      paint_left = 0;
    end else if (lcd_repaint) begin
      busy_auto = 1'b1;
      paint_left = 4;
    end else if (paint_left > 0) begin
      paint_left--;
      if (paint_left == 0) busy_auto = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic gnt_of(input bit side);
    return side ? b_gnt : a_gnt;
  endfunction

  task automatic drive(input bit side, input logic req, input logic we,
                       input logic [4:0] ad, input logic [7:0] dt);
    if (side) begin
      b_req = req; b_we = we; b_addr = ad; b_dat = dt;
    end else begin
      a_req = req; a_we = we; a_addr = ad; a_dat = dt;
    end
  endtask

  task automatic wait_gnt(input bit side);
    int waited = 0;
    while (!gnt_of(side) && waited < 400) begin
      @(negedge CLK12);
      waited++;
    end
    chk(side ? "b_grant_arrives" : "a_grant_arrives", {31'd0, gnt_of(side)}, 1);
  endtask

  // Request, wait for grant, issue w_*[0..n-1] one per cycle, release.
  task automatic txn(input bit side, input int n);
    drive(side, 1'b1, 1'b0, 5'd0, 8'd0);
    wait_gnt(side);
    if (!gnt_of(side)) begin
      drive(side, 1'b0, 1'b0, 5'd0, 8'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      drive(side, 1'b1, w_we[i], w_addr[i], w_dat[i]);
      if (w_we[i]) begin
        m_dirty = 1'b1;
        m_addr = w_addr[i];
        m_dat = w_dat[i];
      end
      @(negedge CLK12);
      chk("wr_we", {31'd0, lcd_we}, {31'd0, w_we[i]});
      chk("wr_addr", {27'd0, lcd_addr}, {27'd0, m_addr});
      chk("wr_dat", {24'd0, lcd_dat}, {24'd0, m_dat});
      chk("gnt_held", {31'd0, gnt_of(side)}, 1);
    end
    drive(side, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge CLK12);
    chk("gnt_released", {31'd0, gnt_of(side)}, 0);
    chk("we_after_release", {31'd0, lcd_we}, 0);
    m_last = side;
  endtask

  task automatic wait_rep(output int t, input int bound);
    int n = 0;
    do begin
      @(negedge CLK12);
      n++;
    end while (!lcd_repaint && n < bound);
    chk("repaint_seen", {31'd0, lcd_repaint}, 1);
    t = cyc;
  endtask

  initial begin
    int t_rel, t1, t2, held, waited;
    bit side, exp_a;
    int n;
    reset_n = 1'b0;
    busy_force = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    repeat (3) @(negedge CLK12);
    chk("rst_a_gnt", {31'd0, a_gnt}, 0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 0);
    chk("rst_lcd_we", {31'd0, lcd_we}, 0);
    chk("rst_lcd_addr", {27'd0, lcd_addr}, 0);
    chk("rst_lcd_dat", {24'd0, lcd_dat}, 0);
    chk("rst_repaint", {31'd0, lcd_repaint}, 0);
    chk("rst_dirty", {31'd0, dirty}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    reset_n = 1'b1;
    @(negedge CLK12);

    // Single write by A, then an immediate repaint (gap counter starts full).
    w_we[0] = 1'b1; w_addr[0] = 5'd3; w_dat[0] = 8'h48;
    txn(0, 1);
    chk("t1_lcd_addr", {27'd0, lcd_addr}, 3);
    chk("t1_lcd_dat", {24'd0, lcd_dat}, 32'h48);
    t_rel = cyc;
    wait_rep(t1, 20);
    chk("t1_rep_latency", t1 - t_rel, 1);
    chk("t1_dirty_cleared", {31'd0, dirty}, 0);

    // Writes shortly after a repaint: next strobe exactly MIN_GAP later.
    repeat (10) @(negedge CLK12);
    for (int i = 0; i < 3; i++) begin
      w_we[i] = 1'b1; w_addr[i] = 5'($urandom_range(0, 31)); w_dat[i] = 8'($urandom);
    end
    txn(1, 3);
    wait_rep(t2, 200);
    chk("gap_exact", t2 - t1, MIN_GAP);
    repeat (10) @(negedge CLK12);

    // Simultaneous requests alternate winners.
    for (int r = 0; r < 3; r++) begin
      exp_a = m_last;
      a_req = 1'b1; b_req = 1'b1;
      @(negedge CLK12);
      chk("tie_a_gnt", {31'd0, a_gnt}, {31'd0, exp_a});
      chk("tie_b_gnt", {31'd0, b_gnt}, {31'd0, !exp_a});
      a_req = 1'b0; b_req = 1'b0;
      @(negedge CLK12);
      chk("tie_released", {30'd0, a_gnt, b_gnt}, 0);
      m_last = !exp_a;
      @(negedge CLK12);
    end

    // Busy LCD blocks grants; the pending request is served once it clears.
    busy_force = 1'b1;
    b_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK12);
      chk("busy_no_gnt", {31'd0, b_gnt}, 0);
      chk("busy_no_rep", {31'd0, lcd_repaint}, 0);
    end
    busy_force = 1'b0;
    @(negedge CLK12);
    chk("busy_gnt_after", {31'd0, b_gnt}, 1);
    for (int i = 0; i < 2; i++) begin
      w_we[i] = 1'b1; w_addr[i] = 5'(i + 20); w_dat[i] = 8'(8'hA0 + i);
    end
    txn(1, 2);
    waited = 0;
    while (m_dirty && waited < 300) begin
      @(negedge CLK12);
      waited++;
    end
    chk("busy_test_repainted", {31'd0, m_dirty}, 0);
    repeat (8) @(negedge CLK12);

    // A holds its request while B also waits.
    a_req = 1'b1; b_req = 1'b1;
    @(negedge CLK12);
    chk("hold_a_gnt", {31'd0, a_gnt}, 1);
`ifdef LCD_ARB_TIMEOUT_EN
    held = 1;
    while (a_gnt && held < 200) begin
      chk("hold_no_timeout", {31'd0, timeout}, 0);
      @(negedge CLK12);
      if (a_gnt) held++;
    end
    chk("to_grant_len", held, TIMEOUT);
    chk("to_pulse", {31'd0, timeout}, 1);
    @(negedge CLK12);
    chk("to_pulse_end", {31'd0, timeout}, 0);
    chk("to_b_gnt", {31'd0, b_gnt}, 1);
    b_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK12);
      chk("to_a_locked", {31'd0, a_gnt}, 0);
    end
    a_req = 1'b0;
    @(negedge CLK12);
    a_req = 1'b1;
    @(negedge CLK12);
    chk("to_a_regranted", {31'd0, a_gnt}, 1);
    a_req = 1'b0;
    @(negedge CLK12);
    chk("to_a_release", {31'd0, a_gnt}, 0);
`else
    held = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK12);
      if (a_gnt && !b_gnt && !timeout) held++;
    end
    chk("hold_cycles", held, 100);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge CLK12);
    chk("hold_release", {31'd0, a_gnt}, 0);
`endif
    m_last = 1'b0;
    repeat (3) @(negedge CLK12);

    // Randomized transactions, with the LCD sometimes never acknowledging.
    for (int t = 0; t < 30; t++) begin
      side = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w_we[i] = ($urandom_range(0, 3) != 0);
        w_addr[i] = 5'($urandom);
        w_dat[i] = 8'($urandom);
      end
      lcd_auto = ($urandom_range(0, 3) != 0);
      txn(side, n);
      repeat ($urandom_range(0, 3)) @(negedge CLK12);
    end
    lcd_auto = 1'b1;

    // Asynchronous reset in the middle of a grant.
    a_req = 1'b1;
    wait_gnt(0);
    a_we = 1'b1; a_addr = 5'd7; a_dat = 8'h5A;
    m_dirty = 1'b1;
    @(negedge CLK12);
    chk("rst_mid_we", {31'd0, lcd_we}, 1);
    #1;
    reset_n = 1'b0;
    m_dirty = 1'b0;
    #1;
    chk("async_a_gnt", {31'd0, a_gnt}, 0);
    chk("async_lcd_we", {31'd0, lcd_we}, 0);
    chk("async_dirty", {31'd0, dirty}, 0);
    chk("async_lcd_addr", {27'd0, lcd_addr}, 0);
    a_req = 1'b0; a_we = 1'b0;
    @(negedge CLK12);
    reset_n = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    @(negedge CLK12);
    chk("post_rst_tie_a", {31'd0, a_gnt}, 1);
    chk("post_rst_tie_b", {31'd0, b_gnt}, 0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) @(negedge CLK12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the 32-character LCD buffer write port (`dat`/`addr`/`we`) between two requesters (A, B) and schedules `repaint` strobes to the `lcd` driver. Arbitration is round-robin, with exclusive grant-and-hold per requester. A repaint is issued only when the buffer is dirty, the LCD is idle and a minimum repaint interval has elapsed. The block sits between the UI content generators and the `lcd` instance, replacing free-running write/repaint logic.

## Interface
- `MIN_GAP`, 2097152 — minimum cycles between consecutive `lcd_repaint` pulses.
- `TIMEOUT`, 64 — maximum grant length in cycles (only with `LCD_ARB_TIMEOUT_EN`).
- `CLK12`  in  1  system clock; everything is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  request buffer access; hold high for the whole transaction.
- `a_we`, `b_we`  in  1  write strobe, valid while granted.
- `a_addr`, `b_addr`  in  5  character address 0..31.
- `a_dat`, `b_dat`  in  8  character code.
- `a_gnt`, `b_gnt`  out  1  grant; at most one is high.
- `lcd_dat`  out  8  registered write data to `lcd`.
- `lcd_addr`  out  5  registered write address to `lcd`.
- `lcd_we`  out  1  registered write enable to `lcd`.
- `lcd_repaint`  out  1  one-cycle repaint strobe to `lcd`.
- `lcd_busy`  in  1  `lcd` busy flag.
- `dirty`  out  1  buffer modified since the last repaint.
- `timeout`  out  1  one-cycle pulse on a forced grant revoke.

## Operation
- States: IDLE, GNT_A, GNT_B, PAINT_ACK, PAINT.
- IDLE, first matching rule wins:
  - If `dirty` and gap counter ≥ MIN_GAP and `!lcd_busy`: pulse `lcd_repaint`, clear `dirty`, zero the gap counter, go to PAINT_ACK.
  - Else if `!lcd_busy` and any request: grant round-robin.
    - If both request, the requester not served last wins.
    - `last` resets to B, so A wins the first tie.
- GNT_x:
  - `x_gnt=1`.
  - Each cycle with `x_gnt & x_req & x_we` is an accepted write: `lcd_addr<=x_addr`, `lcd_dat<=x_dat`, `lcd_we<=1`, `dirty<=1`.
  - Otherwise `lcd_we<=0`; `lcd_addr`/`lcd_dat` hold.
  - `x_req` low → IDLE, `last<=x`.
- PAINT_ACK: wait for `lcd_busy=1`, then go to PAINT. If busy is not seen within 4 cycles, return to IDLE (repaint is treated as done).
- PAINT: wait for `lcd_busy=0`, then go to IDLE. No grants are given while painting, which prevents tearing.
- Gap counter: saturates at MIN_GAP. Reset value is MIN_GAP, so the first repaint is allowed immediately. Width is clog2(MIN_GAP+1).
- A write accepted in the same cycle as a repaint cannot occur: repaint only fires from IDLE.

## Timing
- Reset (asynchronous, immediate):
  - All outputs 0; `lcd_addr`/`lcd_dat` = 0; `dirty=0`.
  - State IDLE; `last`=B; gap counter = MIN_GAP.
- Grant latency: `x_req` sampled high in IDLE → `x_gnt` high the next cycle.
- Write latency: accepted write at cycle n → `lcd_we`/`lcd_addr`/`lcd_dat` valid at n+1, for exactly one cycle per write. Back-to-back writes run at one per cycle.
- Release: `x_req` low at cycle n → `x_gnt` low at n+1. The earliest new grant or repaint is at n+2.
- Repaint strobe is exactly 1 cycle. The minimum distance between strobe rising edges is MIN_GAP cycles.
- `lcd_busy` high in IDLE blocks both grants and repaint. Pending requests wait and are never dropped.

## Configuration
- `LCD_ARB_TIMEOUT_EN` defined:
  - A grant counter runs in GNT_x.
  - At TIMEOUT cycles held, the grant is dropped, `timeout` pulses for 1 cycle, and the state goes to IDLE with `last<=x`.
  - Requester x is locked out until it deasserts `x_req` for at least one cycle.
  - `dirty` keeps any writes already accepted.
- `LCD_ARB_TIMEOUT_EN` undefined: no counter; `timeout` is tied to 0; grants are held indefinitely.

## Test plan
- After reset, A writes `0x48` to address 3 for one cycle, then drops `req` → `lcd_we` 1 cycle with addr 3, data `0x48`; `dirty=1`; `lcd_repaint` pulse follows with `dirty` cleared.
- `a_req` and `b_req` rise in the same cycle, repeated 3 times → grants A, B, A; `a_gnt & b_gnt` never high together.
- Second write burst 10 cycles after a repaint, with MIN_GAP=100 → next `lcd_repaint` exactly 100 cycles after the previous one.
- `lcd_busy` held high for 50 cycles with `b_req` pending → no grant and no repaint; `b_gnt` 1 cycle after busy falls.
- `reset_n` pulsed low mid-grant → `a_gnt`, `lcd_we`, `dirty` 0 asynchronously; state IDLE.
- With `LCD_ARB_TIMEOUT_EN`, TIMEOUT=64, A holds `req` → `a_gnt` drops after 64 cycles; `timeout` pulses; B is granted; A is not regranted until its `req` cycles low.
